flag_branch_unit: RTL and testbench
===================================

# flag_branch_unit

Branch-resolution block that consumes the ALU status flags (negative, zero, overflow, carry_out). It holds the architectural NZCV register, evaluates conditional (B.cond), compare-and-branch (CBZ) and unconditional (B) branches, and returns a registered taken/target result to fetch through a valid/ready handshake. It sits between EX, which produces the flags, and the fetch/PC-select logic, which consumes the result and the flush strobe.

## Interface
Parameters
- `XLEN`, 64, datapath and PC width.

Ports
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  the EX-stage instruction is valid this cycle.
- `ex_setflags`  in  1  the EX instruction writes flags (ADDS/SUBS).
- `ex_neg`, `ex_zero`, `ex_ovf`, `ex_cout`  in  1 each  ALU flags from EX, same cycle.
- `br_valid`  in  1  branch request present.
- `br_ready`  out  1  unit accepts the request this cycle.
- `br_type`  in  2  00 = B, 01 = CBZ, 10 = B.cond, 11 = reserved (treated as not taken).
- `br_cond`  in  4  condition code for B.cond.
- `br_rt_zero`  in  1  CBZ operand register equals zero.
- `br_pc`  in  XLEN  PC of the branch.
- `br_offset`  in  XLEN  sign-extended word offset.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_taken`  out  1  branch taken.
- `out_target`  out  XLEN  branch target.
- `flush`  out  1  one-cycle strobe to squash the wrong-path instruction.
- `flags`  out  4  current {N,Z,C,V} register.

## Operation
- Flag register: when `ex_valid && ex_setflags`, load {N,Z,C,V} <= {ex_neg, ex_zero, ex_cout, ex_ovf} on the edge. The register updates in every FSM state.
- Effective flags used for evaluation are the register value, or the EX flags when they are forwarded (see Configuration).
- Condition codes on effective flags:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E and F are always taken.
- Taken rule: B is always taken; CBZ is taken when `br_rt_zero`; B.cond is taken when its condition holds; type 11 is never taken.
- Target: `br_pc + (br_offset << 2)`, modulo 2^XLEN (wraps, no fault). The target is computed and registered even when the branch is not taken.
- FSM states:
  - IDLE: `br_ready` = 1, except during a no-forward stall. On accept, register taken/target and go to HOLD.
  - HOLD: `out_valid` = 1 and `br_ready` = 0. Outputs stay stable until `out_ready`. On `out_ready`, go to SQUASH if taken, else to IDLE.
  - SQUASH: exactly one cycle with `flush` = 1 and `br_ready` = 1. Any request in this cycle is consumed and discarded (wrong path). Then go to IDLE.

## Timing
- Reset values: state IDLE, NZCV = 0000, `out_valid` = 0, `out_taken` = 0, `out_target` = 0, `flush` = 0. Reset asserted mid-HOLD or mid-SQUASH drops the pending result immediately; no flush is issued.
- Accept-to-result latency is 1 cycle: accept at edge k, so `out_valid` is high after edge k.
- Minimum not-taken throughput is one branch per 2 cycles. Taken throughput is one per 3 cycles, counting the SQUASH cycle.
- `flush` rises on the edge after the handshake cycle in which `out_valid && out_ready && out_taken`.
- A flag write in the same cycle as the HOLD→IDLE transition does not affect the result already held.

## Configuration
- `FLAG_FWD_EN` defined: B.cond accepted in the same cycle as `ex_valid && ex_setflags` evaluates on the EX flags (bypass). There is no stall.
- `FLAG_FWD_EN` undefined: in that case `br_ready` is 0 for a B.cond request. The request is accepted next cycle and evaluated from the updated register, adding 1 stall cycle. B and CBZ never stall.

## Test plan
- Reset, then B with `br_pc` = 0x1000 and offset = 4, `out_ready` = 1 -> `out_valid` 1 cycle later, taken = 1, target = 0x1010. `flush` pulses for 1 cycle, then `br_ready` = 1.
- SUBS producing Z = 1, then B.cond EQ in the next cycle -> taken. The same sequence with NE -> not taken, no flush, back in IDLE.
- B.cond GE in the same cycle as a flag write of N = 1, V = 0 -> not taken with `FLAG_FWD_EN` and no stall. Without the macro, `br_ready` = 0 for 1 cycle and the result is also not taken.
- CBZ with `br_rt_zero` = 0 and offset = -1 at pc 0x0 -> not taken, target = 0xFFFF_FFFF_FFFF_FFFC (wraps).
- Hold `out_ready` low for 5 cycles -> `out_valid`, `out_taken` and `out_target` stay stable and `br_ready` = 0. Request during SQUASH -> discarded, no `out_valid`.
- Assert `reset_n` low while in HOLD -> all outputs return to their reset values asynchronously and NZCV reads 0000.

Source files
------------

// File: rtl/flag_branch_unit.sv
// Branch-resolution unit: holds NZCV, evaluates B / CBZ / B.cond and hands a registered
// taken/target result to fetch. Define FLAG_FWD_EN to bypass same-cycle EX flags into B.cond.
module flag_branch_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ex_valid,
    input  logic            ex_setflags,
    input  logic            ex_neg,
    input  logic            ex_zero,
    input  logic            ex_ovf,
    input  logic            ex_cout,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [1:0]      br_type,
    input  logic [3:0]      br_cond,
    input  logic            br_rt_zero,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_offset,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            flush,
    output logic [3:0]      flags
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_SQUASH = 2'd2
    } state_t;

    localparam logic [1:0] BT_B    = 2'b00;
    localparam logic [1:0] BT_CBZ  = 2'b01;
    localparam logic [1:0] BT_COND = 2'b10;

    // Flags are packed {N,Z,C,V}.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    cond_holds = z;
            4'h1:    cond_holds = !z;
            4'h2:    cond_holds = c;
            4'h3:    cond_holds = !c;
            4'h4:    cond_holds = n;
            4'h5:    cond_holds = !n;
            4'h6:    cond_holds = v;
            4'h7:    cond_holds = !v;
            4'h8:    cond_holds = c & !z;
            4'h9:    cond_holds = !c | z;
            4'hA:    cond_holds = (n == v);
            4'hB:    cond_holds = (n != v);
            4'hC:    cond_holds = !z & (n == v);
            4'hD:    cond_holds = z | (n != v);
            default: cond_holds = 1'b1;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        nzcv_q, nzcv_d;
    logic              taken_q, taken_d;
    logic [XLEN-1:0]   target_q, target_d;

    logic              setf_s;
    logic [3:0]        ex_nzcv_s;
    logic [3:0]        eff_nzcv_s;
    logic              stall_s;
    logic              taken_eval_s;
    logic [XLEN-1:0]   target_eval_s;

    // Branch evaluation on the effective flags; without the bypass a B.cond racing a flag write waits a cycle.
    always_comb begin
        setf_s        = ex_valid & ex_setflags;
        ex_nzcv_s     = {ex_neg, ex_zero, ex_cout, ex_ovf};
`ifdef FLAG_FWD_EN
        eff_nzcv_s    = setf_s ? ex_nzcv_s : nzcv_q;
        stall_s       = 1'b0;
`else
        eff_nzcv_s    = nzcv_q;
        stall_s       = br_valid & (br_type == BT_COND) & setf_s;
`endif
        case (br_type)
            BT_B:    taken_eval_s = 1'b1;
            BT_CBZ:  taken_eval_s = br_rt_zero;
            BT_COND: taken_eval_s = cond_holds(br_cond, eff_nzcv_s);
            default: taken_eval_s = 1'b0;
        endcase
        target_eval_s = br_pc + (br_offset << 2);
        nzcv_d        = setf_s ? ex_nzcv_s : nzcv_q;
    end

    // Handshake FSM: next state, result capture and request acceptance.
    always_comb begin
        state_d  = state_q;
        taken_d  = taken_q;
        target_d = target_q;
        br_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                br_ready = !stall_s;
                if (br_valid && !stall_s) begin
                    taken_d  = taken_eval_s;
                    target_d = target_eval_s;
                    state_d  = S_HOLD;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = taken_q ? S_SQUASH : S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_SQUASH: begin
                // A request here is on the wrong path: accepted and dropped.
                br_ready = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, flag and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            nzcv_q   <= 4'b0000;
            taken_q  <= 1'b0;
            target_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            nzcv_q   <= nzcv_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    assign out_valid  = (state_q == S_HOLD);
    assign flush      = (state_q == S_SQUASH);
    assign out_taken  = taken_q;
    assign out_target = target_q;
    assign flags      = nzcv_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed cases plus randomized traffic against a
// behavioural model, with results checked by a scoreboard monitor.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ex_valid = 1'b0, ex_setflags = 1'b0;
    logic        ex_neg = 1'b0, ex_zero = 1'b0, ex_ovf = 1'b0, ex_cout = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [1:0]  br_type = 2'b00;
    logic [3:0]  br_cond = 4'h0;
    logic        br_rt_zero = 1'b0;
    logic [63:0] br_pc = 64'd0, br_offset = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_taken;
    logic [63:0] out_target;
    logic        flush;
    logic [3:0]  flags;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        taken;
        logic [63:0] target;
    } result_t;
    result_t exp_q[$];

    flag_branch_unit #(.XLEN(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_setflags(ex_setflags),
        .ex_neg(ex_neg), .ex_zero(ex_zero), .ex_ovf(ex_ovf), .ex_cout(ex_cout),
        .br_valid(br_valid), .br_ready(br_ready), .br_type(br_type), .br_cond(br_cond),
        .br_rt_zero(br_rt_zero), .br_pc(br_pc), .br_offset(br_offset),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_target(out_target), .flush(flush), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural condition semantics: base test chosen by cond[3:1], odd codes invert, 0xF is AL.
    function automatic logic ref_cond(input logic [3:0] c, input logic n, input logic z,
                                      input logic cf, input logic v);
        logic r;
        logic [2:0] base;
        base = c[3:1];
        case (base)
            3'd0:    r = z;
            3'd1:    r = cf;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = cf && !z;
            3'd5:    r = (n == v);
            3'd6:    r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[0] && c != 4'hF) r = !r;
        return r;
    endfunction

    // Reference model: 0 = waiting for a branch, 1 = result pending, 2 = squash cycle.
    int          m_state = 0;
    logic [3:0]  m_flags = 4'b0000;
    result_t     m_held;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_state = 0;
                m_flags = 4'b0000;
                exp_q.delete();
            end else begin
                logic setf, stall, exp_ready, tk;
                logic n, z, cf, v;
                result_t r;
                setf = ex_valid && ex_setflags;
`ifdef FLAG_FWD_EN
                stall = 1'b0;
`else
                stall = br_valid && (br_type == 2'b10) && setf;
`endif
                exp_ready = (m_state == 0 && !stall) || (m_state == 2);
                chk("br_ready", {63'd0, br_ready}, {63'd0, exp_ready});
                chk("out_valid", {63'd0, out_valid}, {63'd0, (m_state == 1)});
                chk("flush", {63'd0, flush}, {63'd0, (m_state == 2)});
                chk("flags", {60'd0, flags}, {60'd0, m_flags});
                if (m_state == 1) begin
                    chk("held_taken", {63'd0, out_taken}, {63'd0, m_held.taken});
                    chk("held_target", out_target, m_held.target);
                end
                if (m_state == 0 && br_valid && exp_ready) begin
                    {n, z, cf, v} = m_flags;
`ifdef FLAG_FWD_EN
                    if (setf) {n, z, cf, v} = {ex_neg, ex_zero, ex_cout, ex_ovf};
`endif
                    case (br_type)
                        2'b00:   tk = 1'b1;
                        2'b01:   tk = br_rt_zero;
                        2'b10:   tk = ref_cond(br_cond, n, z, cf, v);
                        default: tk = 1'b0;
                    endcase
                    r.taken  = tk;
                    r.target = br_pc + br_offset * 64'd4;
                    exp_q.push_back(r);
                    m_held  = r;
                    m_state = 1;
                end else if (m_state == 1) begin
                    if (out_ready) m_state = m_held.taken ? 2 : 0;
                end else if (m_state == 2) begin
                    m_state = 0;
                end
                if (setf) m_flags = {ex_neg, ex_zero, ex_cout, ex_ovf};
            end
        end
    end

    // Scoreboard monitor: every completed handshake must match the oldest expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_result", 64'd1, 64'd0);
                end else begin
                    result_t e;
                    e = exp_q.pop_front();
                    chk("sb_taken", {63'd0, out_taken}, {63'd0, e.taken});
                    chk("sb_target", out_target, e.target);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic n, input logic z, input logic c, input logic v);
        ex_valid = 1'b1; ex_setflags = 1'b1;
        ex_neg = n; ex_zero = z; ex_cout = c; ex_ovf = v;
    endtask

    // Holds a request until accepted; any EX flag write lasts only the first cycle.
    task automatic issue(input logic [1:0] t, input logic [3:0] c, input logic rz,
                         input logic [63:0] pc, input logic [63:0] off, output int cycles);
        logic acc;
        br_valid = 1'b1; br_type = t; br_cond = c; br_rt_zero = rz;
        br_pc = pc; br_offset = off;
        cycles = 0;
        acc = 1'b0;
        while (!acc && cycles < 20) begin
            @(negedge clk);
            acc = br_ready;
            sync();
            ex_valid = 1'b0;
            cycles++;
        end
        br_valid = 1'b0;
        if (!acc) chk("accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_result(input string name, input logic tk, input logic [63:0] tgt);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({name, "_taken"}, {63'd0, out_taken}, {63'd0, tk});
        chk({name, "_target"}, out_target, tgt);
    endtask

    initial begin
        int cyc;
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_taken", {63'd0, out_taken}, 64'd0);
        chk("rst_out_target", out_target, 64'd0);
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_flags", {60'd0, flags}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        sync();

        // Unconditional branch, then flush pulse, then ready again.
        issue(2'b00, 4'h0, 1'b0, 64'h1000, 64'd4, cyc);
        wait_result("b_basic", 1'b1, 64'h1010);
        @(negedge clk);
        chk("b_flush", {63'd0, flush}, 64'd1);
        @(negedge clk);
        chk("b_flush_end", {63'd0, flush}, 64'd0);
        chk("b_ready_after", {63'd0, br_ready}, 64'd1);

        // SUBS sets Z, then EQ taken / NE not taken.
        sync();
        set_flags(1'b0, 1'b1, 1'b1, 1'b0);
        sync();
        ex_valid = 1'b0;
        issue(2'b10, 4'h0, 1'b0, 64'h2000, 64'h10, cyc);
        wait_result("beq", 1'b1, 64'h2040);
        repeat (3) sync();
        issue(2'b10, 4'h1, 1'b0, 64'h3000, 64'h1, cyc);
        wait_result("bne", 1'b0, 64'h3004);
        @(negedge clk);
        chk("bne_no_flush", {63'd0, flush}, 64'd0);
        chk("bne_idle_ready", {63'd0, br_ready}, 64'd1);

        // GE racing a flag write of N=1, V=0.
        sync();
        set_flags(1'b1, 1'b0, 1'b0, 1'b0);
        issue(2'b10, 4'hA, 1'b0, 64'h4000, 64'h2, cyc);
`ifdef FLAG_FWD_EN
        chk("bge_accept_cycles", cyc, 64'd1);
`else
        chk("bge_accept_cycles", cyc, 64'd2);
`endif
        wait_result("bge", 1'b0, 64'h4008);

        // CBZ not taken with wrapping target.
        repeat (2) sync();
        issue(2'b01, 4'h0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, cyc);
        wait_result("cbz_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);

        // Stall the consumer, then a wrong-path request during SQUASH.
        repeat (2) sync();
        out_ready = 1'b0;
        issue(2'b00, 4'h0, 1'b0, 64'h5000, 64'h8, cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_target", out_target, 64'h5020);
            chk("hold_ready", {63'd0, br_ready}, 64'd0);
        end
        sync();
        out_ready = 1'b1;
        sync();
        br_valid = 1'b1; br_type = 2'b00; br_pc = 64'h9000; br_offset = 64'd1;
        @(negedge clk);
        chk("squash_flush", {63'd0, flush}, 64'd1);
        sync();
        br_valid = 1'b0;
        @(negedge clk);
        chk("squash_discard", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset while a result is held.
        sync();
        set_flags(1'b1, 1'b1, 1'b1, 1'b1);
        sync();
        ex_valid = 1'b0;
        out_ready = 1'b0;
        issue(2'b00, 4'h0, 1'b0, 64'h6000, 64'h4, cyc);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_out_taken", {63'd0, out_taken}, 64'd0);
        chk("arst_out_target", out_target, 64'd0);
        chk("arst_flush", {63'd0, flush}, 64'd0);
        chk("arst_flags", {60'd0, flags}, 64'd0);
        repeat (2) sync();
        reset_n = 1'b1;
        out_ready = 1'b1;
        sync();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ex_valid    = ($urandom_range(0, 2) == 0);
            ex_setflags = $urandom_range(0, 1);
            {ex_neg, ex_zero, ex_cout, ex_ovf} = 4'($urandom);
            br_valid    = $urandom_range(0, 1);
            br_type     = 2'($urandom);
            br_cond     = 4'($urandom);
            br_rt_zero  = $urandom_range(0, 1);
            br_pc       = {$urandom, $urandom};
            br_offset   = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                      : 64'($signed(8'($urandom)));
            out_ready   = ($urandom_range(0, 9) < 7);
            sync();
        end
        br_valid = 1'b0; ex_valid = 1'b0; out_ready = 1'b1;
        repeat (6) sync();
        chk("sb_drained", exp_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
